// File: rtl/arbiter_pkg.sv
// arbiter_pkg: shared state type and one-hot to index conversion for the round-robin arbiter
package arbiter_pkg;
    localparam int MAX_WAYS = 64;

    typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

    function automatic int onehot_to_index(input logic [MAX_WAYS-1:0] onehot);
        int r;
        r = 0;
        for (int i = 0; i < MAX_WAYS; i++)
            if (onehot[i]) r = i;
        return r;
    endfunction
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: first set request bit searching upward from pointer, wrapping at NUMBER_WAYS
module rr_priority_pick #(
    parameter int NUMBER_WAYS = 8,
    parameter int PW = $clog2(NUMBER_WAYS)
) (
    input  logic [NUMBER_WAYS-1:0] request,
    input  logic [PW-1:0]          pointer,
    output logic [NUMBER_WAYS-1:0] winner,
    output logic                   any
);
    logic [PW-1:0] idx;
    int            s;

    always_comb begin
        winner = '0;
        any = 1'b0;
        s = 0;
        idx = '0;
        for (int k = 0; k < NUMBER_WAYS; k++) begin
            s = int'(pointer) + k;
            s = (s >= NUMBER_WAYS) ? s - NUMBER_WAYS : s;
            idx = PW'(s);
            if (!any && request[idx]) begin
                winner[idx] = 1'b1;
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/arbiter_rr_onehot.sv
// arbiter_rr_onehot: round-robin one-hot arbiter with grant hold until ack
// ARBITER_RR_TIMEOUT_EN adds a hold counter that force-releases after MAX_HOLD_CYCLES
module arbiter_rr_onehot
    import arbiter_pkg::*;
#(
    parameter int NUMBER_WAYS = 8,
    parameter int MAX_HOLD_CYCLES = 16
) (
    input  logic                           clk_in,
    input  logic                           reset_in,
    input  logic [NUMBER_WAYS-1:0]         request_in,
    input  logic                           ack_in,
    output logic [NUMBER_WAYS-1:0]         sel_out,
    output logic                           grant_valid_out,
    output logic [$clog2(NUMBER_WAYS)-1:0] grant_index_out,
    output logic                           timeout_out
);
    localparam int IW = $clog2(NUMBER_WAYS);

    state_t                 state;
    logic [NUMBER_WAYS-1:0] sel, win;
    logic [IW-1:0]          ptr, idx, nxt_ptr, pick_ptr;
    logic                   any, hold_hit, release_g;

    assign idx       = IW'(onehot_to_index(MAX_WAYS'(sel)));
    assign nxt_ptr   = (idx == IW'(NUMBER_WAYS - 1)) ? '0 : idx + 1'b1;
    assign release_g = (state == GRANT) && (ack_in || hold_hit);
    assign pick_ptr  = release_g ? nxt_ptr : ptr;

    // Masking with sel excludes the way being released; sel is zero in IDLE
    rr_priority_pick #(.NUMBER_WAYS(NUMBER_WAYS)) u_pick (
        .request(request_in & ~sel),
        .pointer(pick_ptr),
        .winner (win),
        .any    (any)
    );

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            state <= IDLE;
            ptr   <= '0;
            sel   <= '0;
        end else if (state == IDLE || release_g) begin
            if (release_g) ptr <= nxt_ptr;
            state <= any ? GRANT : IDLE;
            sel   <= win;
        end
    end

`ifdef ARBITER_RR_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD_CYCLES + 1);

    logic [HW-1:0] hold;
    logic          timeout_q;

    assign hold_hit = (state == GRANT) && (hold == HW'(MAX_HOLD_CYCLES - 1));

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            hold      <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold      <= (state == IDLE || release_g) ? '0 : hold + 1'b1;
            timeout_q <= hold_hit && !ack_in;
        end
    end

    assign timeout_out = timeout_q;
`else
    assign hold_hit    = 1'b0;
    assign timeout_out = 1'b0;
`endif

    assign sel_out         = sel;
    assign grant_valid_out = (state == GRANT);
    assign grant_index_out = idx;
endmodule

// File: tb/tb_arbiter_rr_onehot.sv
// tb_arbiter_rr_onehot: directed scoreboard bench for arbiter_rr_onehot (NUMBER_WAYS=8, MAX_HOLD_CYCLES=4)
module tb_arbiter_rr_onehot;
    typedef struct {
        string      name;
        logic       v;
        logic [7:0] s;
        logic [2:0] i;
        logic       t;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_in = 1'b0;
    logic [7:0] request_in = '0;
    logic       ack_in = 1'b0;
    logic [7:0] sel_out;
    logic       grant_valid_out;
    logic [2:0] grant_index_out;
    logic       timeout_out;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    arbiter_rr_onehot #(.NUMBER_WAYS(8), .MAX_HOLD_CYCLES(4)) dut (
        .clk_in         (clk),
        .reset_in       (reset_in),
        .request_in     (request_in),
        .ack_in         (ack_in),
        .sel_out        (sel_out),
        .grant_valid_out(grant_valid_out),
        .grant_index_out(grant_index_out),
        .timeout_out    (timeout_out)
    );

    always #5 clk = ~clk;

    task automatic step(input string name, input logic rn, input logic [7:0] req, input logic ack,
                        input logic ev, input int ei, input logic et);
        exp_t e;
        logic [7:0] one;
        @(negedge clk);
        reset_in = rn;
        request_in = req;
        ack_in = ack;
        one = 8'd1;
        e.name = name;
        e.v = ev;
        e.i = ev ? 3'(ei) : 3'd0;
        e.s = ev ? (one << ei) : 8'h00;
        e.t = et;
        q.push_back(e);
    endtask

    always begin
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_checks++;
            if (grant_valid_out !== e.v || sel_out !== e.s || grant_index_out !== e.i || timeout_out !== e.t) begin
                n_fail++;
                $display("FAIL %s: got valid=%b sel=%b idx=%0d to=%b, expected valid=%b sel=%b idx=%0d to=%b",
                         e.name, grant_valid_out, sel_out, grant_index_out, timeout_out, e.v, e.s, e.i, e.t);
            end
        end
    end

    initial begin
        for (int k = 0; k < 5; k++) step("reset_hold", 1'b0, 8'hFF, 1'b0, 1'b0, 0, 1'b0);
        step("single_grant", 1'b1, 8'h04, 1'b0, 1'b1, 2, 1'b0);
        step("ack_drop", 1'b1, 8'h00, 1'b1, 1'b0, 0, 1'b0);
        step("idle_norq", 1'b1, 8'h00, 1'b0, 1'b0, 0, 1'b0);
        step("idle_ack", 1'b1, 8'h00, 1'b1, 1'b0, 0, 1'b0);
        step("reset_mid", 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0);
        step("rotate", 1'b1, 8'hFF, 1'b1, 1'b1, 0, 1'b0);
        for (int k = 1; k <= 8; k++) step("rotate", 1'b1, 8'hFF, 1'b1, 1'b1, k % 8, 1'b0);
        for (int k = 1; k <= 6; k++) step("rotate2", 1'b1, 8'hFF, 1'b1, 1'b1, k, 1'b0);
        step("wrap_to0", 1'b1, 8'h41, 1'b1, 1'b1, 0, 1'b0);
        step("then6", 1'b1, 8'h41, 1'b1, 1'b1, 6, 1'b0);
        step("drain", 1'b1, 8'h00, 1'b1, 1'b0, 0, 1'b0);
        step("grant3", 1'b1, 8'h08, 1'b0, 1'b1, 3, 1'b0);
        for (int k = 0; k < 2; k++) step("hold3", 1'b1, 8'h80, 1'b0, 1'b1, 3, 1'b0);
        step("ack3_to7", 1'b1, 8'h80, 1'b1, 1'b1, 7, 1'b0);
        step("drain2", 1'b1, 8'h00, 1'b1, 1'b0, 0, 1'b0);
        step("grant1", 1'b1, 8'h02, 1'b0, 1'b1, 1, 1'b0);
`ifdef ARBITER_RR_TIMEOUT_EN
        for (int k = 0; k < 3; k++) step("hold1", 1'b1, 8'h02, 1'b0, 1'b1, 1, 1'b0);
        step("timeout", 1'b1, 8'h02, 1'b0, 1'b0, 0, 1'b1);
        step("to_pulse_end", 1'b1, 8'h00, 1'b0, 1'b0, 0, 1'b0);
        step("ptr_after_to", 1'b1, 8'hFF, 1'b0, 1'b1, 2, 1'b0);
        step("ack2", 1'b1, 8'hFF, 1'b1, 1'b1, 3, 1'b0);
        for (int k = 0; k < 3; k++) step("hold3b", 1'b1, 8'hFF, 1'b0, 1'b1, 3, 1'b0);
        step("ack_and_to", 1'b1, 8'hFF, 1'b1, 1'b1, 4, 1'b0);
`else
        for (int k = 0; k < 8; k++) step("hold1", 1'b1, 8'h02, 1'b0, 1'b1, 1, 1'b0);
        step("ack1", 1'b1, 8'hFF, 1'b1, 1'b1, 2, 1'b0);
`endif
        step("reset_in_grant", 1'b0, 8'hFF, 1'b0, 1'b0, 0, 1'b0);
        step("post_reset", 1'b1, 8'hFF, 1'b0, 1'b1, 0, 1'b0);
        for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expected responses left, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
